// File: rtl/stream_extrema_tracker.sv
// Frame-based running max/min tracker over a valid/ready sample stream.
// Collects LEN unsigned samples, then holds max/min, their first-occurrence
// indices and the count of samples equal to the max until the consumer
// takes the result. LEN must be at least 2.
module stream_extrema_tracker #(
    parameter int unsigned N    = 4,
    parameter int unsigned LEN  = 8,
    localparam int unsigned IDXW = $clog2(LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    max_val,
    output logic [N-1:0]    min_val,
    output logic [IDXW-1:0] max_idx,
    output logic [IDXW-1:0] min_idx,
    output logic [IDXW:0]   max_cnt
);

    localparam int unsigned CNTW = IDXW + 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic            out_valid_d;
    logic [IDXW-1:0] cnt;
    logic            accept;
    logic            last;

    // Ready is a pure decode of the state; clear drops any sample offered with it.
    assign in_ready = (state == ACC);
    assign accept   = in_valid && in_ready && !clear;
    assign last     = (cnt == IDXW'(LEN - 1));

    // State and result-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state logic: frame end enters HOLD, consumer handshake returns to ACC.
    always_comb begin
        state_d     = state;
        out_valid_d = out_valid;
        if (clear) begin
            state_d     = ACC;
            out_valid_d = 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept && last) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d     = ACC;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ACC;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Sample index within the frame; explicit wrap so LEN need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last ? '0 : cnt + IDXW'(1);
        end
    end

    // Running extrema; index 0 seeds both paths, later samples update them independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
            max_cnt <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                max_val <= in_data;
                min_val <= in_data;
                max_idx <= '0;
                min_idx <= '0;
                max_cnt <= CNTW'(1);
            end else begin
                if (in_data > max_val) begin
                    max_val <= in_data;
                    max_idx <= cnt;
                    max_cnt <= CNTW'(1);
                end else if (in_data == max_val) begin
                    max_cnt <= max_cnt + CNTW'(1);
                end
                if (in_data < min_val) begin
                    min_val <= in_data;
                    min_idx <= cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_extrema_tracker.sv
// Self-checking bench for stream_extrema_tracker (N=4, LEN=8).
module tb_stream_extrema_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] max_val;
    logic [3:0] min_val;
    logic [2:0] max_idx;
    logic [2:0] min_idx;
    logic [3:0] max_cnt;

    int passed = 0;
    int total  = 0;
    logic [3:0] fr [8];

    stream_extrema_tracker #(.N(4), .LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .min_val   (min_val),
        .max_idx   (max_idx),
        .min_idx   (min_idx),
        .max_cnt   (max_cnt)
    );

    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: plain scan over the whole frame.
    task automatic expect_result(input string tag);
        logic [3:0] mx;
        logic [3:0] mn;
        int mxi;
        int mni;
        int c;
        mx = fr[0];
        mn = fr[0];
        for (int i = 0; i < 8; i++) begin
            if (fr[i] > mx) mx = fr[i];
            if (fr[i] < mn) mn = fr[i];
        end
        mxi = -1;
        mni = -1;
        c = 0;
        for (int i = 0; i < 8; i++) begin
            if (fr[i] == mx && mxi < 0) mxi = i;
            if (fr[i] == mn && mni < 0) mni = i;
            if (fr[i] == mx) c++;
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
        chk({tag, ".max_val"},   32'(max_val),   32'(mx));
        chk({tag, ".min_val"},   32'(min_val),   32'(mn));
        chk({tag, ".max_idx"},   32'(max_idx),   32'(mxi));
        chk({tag, ".min_idx"},   32'(min_idx),   32'(mni));
        chk({tag, ".max_cnt"},   32'(max_cnt),   32'(c));
    endtask

    // Offer fr[first..7]; gaps<0 picks random bubbles. Ends on the negedge after the last accept.
    task automatic send_frame(input int gaps, input int first);
        int k;
        for (int i = first; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fr[i];
            if (i < 7) begin
                k = (gaps < 0) ? int'($urandom_range(0, 2)) : gaps;
                repeat (k) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 4'($urandom);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Keep the result stalled for 'stall' further cycles, then take it.
    task automatic handshake(input string tag, input int stall, input bit hold_v, input logic [3:0] hold_d);
        if (hold_v) begin
            in_valid = 1'b1;
            in_data  = hold_d;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            expect_result($sformatf("%s.stall%0d", tag, s));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        // Reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.max_val",   32'(max_val),   32'd0);
        chk("rst.min_val",   32'(min_val),   32'd0);
        chk("rst.max_cnt",   32'(max_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, one-cycle latency, one-cycle valid.
        fr = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd15, 4'd0, 4'd7, 4'd15};
        out_ready = 1'b1;
        send_frame(0, 0);
        expect_result("basic");
        handshake("basic", 0, 1'b0, 4'd0);

        // All equal.
        fr = '{default: 4'd6};
        send_frame(0, 0);
        expect_result("equal");
        handshake("equal", 0, 1'b0, 4'd0);

        // Backpressure with a sample held pending during HOLD.
        fr = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd1};
        out_ready = 1'b0;
        send_frame(0, 0);
        expect_result("bp");
        handshake("bp", 5, 1'b1, 4'd0);
        fr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        send_frame(0, 1);
        expect_result("bp_next");
        handshake("bp_next", 0, 1'b0, 4'd0);

        // Bubbles: valid pattern 1,0,0,1,...
        fr = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd15, 4'd0, 4'd7, 4'd15};
        send_frame(2, 0);
        expect_result("bubble");
        handshake("bubble", 0, 1'b0, 4'd0);

        // clear mid-frame drops partial progress and the coincident sample.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'd9;
        end
        @(negedge clk);
        clear   = 1'b1;
        in_data = 4'd15;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr.out_valid", 32'(out_valid), 32'd0);
        fr = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd4};
        send_frame(0, 0);
        expect_result("clr");
        handshake("clr", 0, 1'b0, 4'd0);

        // clear during HOLD.
        for (int i = 0; i < 8; i++) fr[i] = 4'($urandom);
        out_ready = 1'b0;
        send_frame(0, 0);
        expect_result("clrh");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clrh.out_valid", 32'(out_valid), 32'd0);
        chk("clrh.in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) fr[i] = 4'($urandom);
        send_frame(0, 0);
        expect_result("clrh_next");
        handshake("clrh_next", 0, 1'b0, 4'd0);

        // Asynchronous reset mid-frame, between edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'(12 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready",  32'(in_ready),  32'd1);
        chk("arst.max_val",   32'(max_val),   32'd0);
        chk("arst.min_val",   32'(min_val),   32'd0);
        chk("arst.max_idx",   32'(max_idx),   32'd0);
        chk("arst.min_idx",   32'(min_idx),   32'd0);
        chk("arst.max_cnt",   32'(max_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fr[0] = 4'd11;
        for (int i = 1; i < 8; i++) fr[i] = 4'($urandom_range(0, 10));
        send_frame(0, 0);
        expect_result("arst");
        handshake("arst", 0, 1'b0, 4'd0);

        // Randomized frames: narrow value ranges to force ties, random bubbles and stalls.
        for (int f = 0; f < 30; f++) begin
            int stall;
            int hi;
            hi = (f % 3 == 0) ? 15 : ((f % 3 == 1) ? 3 : 1);
            for (int i = 0; i < 8; i++) fr[i] = 4'($urandom_range(0, hi));
            stall = int'($urandom_range(0, 3));
            out_ready = (stall == 0);
            send_frame(-1, 0);
            expect_result($sformatf("rnd%0d", f));
            handshake($sformatf("rnd%0d", f), stall, 1'b0, 4'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
